irqctl: RTL and testbench

IRQCTL -- requirements
Module: irqctl

---
 rtl/irqctl.sv | 187 ++++++++++++++++++
 tb/tb_irqctl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/irqctl.sv
// irqctl: four-line interrupt controller with pending/mask registers and a
// three-state request/service handshake (IDLE -> REQ -> SVC -> IDLE).
// All state changes on the falling edge of clk. reset is synchronous, active-low.
// Line 0 has the highest priority.
// Optional build macro IRQCTL_EDGE_EN: when defined, a line pends only on a
// 0->1 transition; otherwise a line pends on every edge it is held high.
module irqctl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq,
  input  logic       ie,
  input  logic       mask_we,
  input  logic [3:0] mask_in,
  output logic [3:0] mask_out,
  output logic [3:0] pend_out,
  output logic       irq_req,
  input  logic       irq_ack,
  output logic [1:0] vector,
  input  logic       eoi,
  output logic       in_service
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] pend_r;
  logic [3:0] mask_r;
  logic [1:0] vector_r;
  logic       irq_req_r;
  logic       in_service_r;

  logic [3:0] set_s;
  logic [3:0] clr_s;
  logic [3:0] elig_s;
  logic [3:0] pend_nxt_s;
  logic [1:0] vector_nxt_s;
  logic       irq_req_nxt_s;
  logic       in_service_nxt_s;

  // Fixed-priority encoder: lowest-numbered set bit wins.
  function automatic logic [1:0] prio_enc(input logic [3:0] v);
    logic [1:0] r;
    if (v[0]) begin
      r = 2'd0;
    end else if (v[1]) begin
      r = 2'd1;
    end else if (v[2]) begin
      r = 2'd2;
    end else begin
      r = 2'd3;
    end
    return r;
  endfunction

  // One-hot decode of a line index.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = 4'b0001;
      2'd1:    r = 4'b0010;
      2'd2:    r = 4'b0100;
      2'd3:    r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

`ifdef IRQCTL_EDGE_EN
  logic [3:0] irq_prev_r;

  // Previous sample of the irq lines, used for rising-edge detection.
  always_ff @(negedge clk) begin
    if (!reset) begin
      irq_prev_r <= 4'h0;
    end else begin
      irq_prev_r <= irq;
    end
  end

  // Rising-edge capture: a line pends only when it goes 0->1.
  always_comb begin
    set_s = irq & ~irq_prev_r;
  end
`else
  // Level capture: a line pends on every edge it is high.
  always_comb begin
    set_s = irq;
  end
`endif

  // Eligibility, pend clear on acknowledge, and pend next value (set wins over clear).
  always_comb begin
    elig_s = pend_r & ~mask_r;
    if ((state_r == ST_REQ) && irq_ack) begin
      clr_s = onehot(vector_r);
    end else begin
      clr_s = 4'h0;
    end
    pend_nxt_s = (pend_r & ~clr_s) | set_s;
  end

  // State register.
  always_ff @(negedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; acknowledge takes precedence over withdrawal when ie drops.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ie && (|elig_s)) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_nxt_s = ST_SVC;
        end else if (!ie) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_SVC: begin
        if (eoi) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SVC;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output next values; vector only moves when a new request is launched.
  always_comb begin
    irq_req_nxt_s    = (state_nxt_s == ST_REQ);
    in_service_nxt_s = (state_nxt_s == ST_SVC);
    if ((state_r == ST_IDLE) && (state_nxt_s == ST_REQ)) begin
      vector_nxt_s = prio_enc(elig_s);
    end else begin
      vector_nxt_s = vector_r;
    end
  end

  // Registered outputs, pending and mask registers.
  always_ff @(negedge clk) begin
    if (!reset) begin
      pend_r       <= 4'h0;
      mask_r       <= 4'hF;
      vector_r     <= 2'd0;
      irq_req_r    <= 1'b0;
      in_service_r <= 1'b0;
    end else begin
      pend_r       <= pend_nxt_s;
      if (mask_we) begin
        mask_r <= mask_in;
      end else begin
        mask_r <= mask_r;
      end
      vector_r     <= vector_nxt_s;
      irq_req_r    <= irq_req_nxt_s;
      in_service_r <= in_service_nxt_s;
    end
  end

  assign mask_out   = mask_r;
  assign pend_out   = pend_r;
  assign vector     = vector_r;
  assign irq_req    = irq_req_r;
  assign in_service = in_service_r;

endmodule

// File: tb/tb_irqctl.sv
// Scoreboard bench for irqctl: the stimulus process drives one falling edge at
// a time and queues the hand-computed register state expected after it; the
// monitor pops and compares on the following rising edge.
module tb_irqctl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq = 4'h0;
  logic       ie = 1'b0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_in = 4'h0;
  logic [3:0] mask_out;
  logic [3:0] pend_out;
  logic       irq_req;
  logic       irq_ack = 1'b0;
  logic [1:0] vector;
  logic       eoi = 1'b0;
  logic       in_service;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [3:0] mask;
    logic [3:0] pend;
    logic       req;
    logic       svc;
    logic [1:0] vec;
  } exp_t;

  exp_t sb[$];
  bit   stim_done = 1'b0;

`ifdef IRQCTL_EDGE_EN
  localparam logic [3:0] HELD_P = 4'h0;
`else
  localparam logic [3:0] HELD_P = 4'h4;
`endif

  irqctl dut (
    .clk(clk), .reset(reset), .irq(irq), .ie(ie), .mask_we(mask_we),
    .mask_in(mask_in), .mask_out(mask_out), .pend_out(pend_out),
    .irq_req(irq_req), .irq_ack(irq_ack), .vector(vector), .eoi(eoi),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  // Apply one falling edge with the current inputs, then queue the expectation.
  task automatic tick(input string name, input logic [3:0] m, input logic [3:0] p,
                      input logic r, input logic s, input logic [1:0] v);
    exp_t e;
    @(negedge clk);
    #1;
    e.name = name; e.mask = m; e.pend = p; e.req = r; e.svc = s; e.vec = v;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation on the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (mask_out !== e.mask || pend_out !== e.pend || irq_req !== e.req ||
            in_service !== e.svc || vector !== e.vec) begin
          errors++;
          $display("FAIL %s: got mask=%h pend=%h req=%b svc=%b vec=%0d, want mask=%h pend=%h req=%b svc=%b vec=%0d",
                   e.name, mask_out, pend_out, irq_req, in_service, vector,
                   e.mask, e.pend, e.req, e.svc, e.vec);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    // reset
    reset = 1'b0; tick("reset", 4'hF, 4'h0, 1'b0, 1'b0, 2'd0); reset = 1'b1;

    // basic request/ack/eoi on line 2
    mask_we = 1'b1; mask_in = 4'h0; ie = 1'b1;
    tick("mask_wr", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0); mask_we = 1'b0;
    irq = 4'b0100; tick("l2_pend", 4'h0, 4'h4, 1'b0, 1'b0, 2'd0); irq = 4'h0;
    tick("l2_req", 4'h0, 4'h4, 1'b1, 1'b0, 2'd2);
    irq_ack = 1'b1; tick("l2_ack", 4'h0, 4'h0, 1'b0, 1'b1, 2'd2); irq_ack = 1'b0;
    tick("l2_svc", 4'h0, 4'h0, 1'b0, 1'b1, 2'd2);
    eoi = 1'b1; tick("l2_eoi", 4'h0, 4'h0, 1'b0, 1'b0, 2'd2); eoi = 1'b0;

    // two lines at once: 1 before 3
    irq = 4'b1010; tick("pr_pend", 4'h0, 4'hA, 1'b0, 1'b0, 2'd2); irq = 4'h0;
    tick("pr_req1", 4'h0, 4'hA, 1'b1, 1'b0, 2'd1);
    irq_ack = 1'b1; tick("pr_ack1", 4'h0, 4'h8, 1'b0, 1'b1, 2'd1); irq_ack = 1'b0;
    eoi = 1'b1; tick("pr_eoi1", 4'h0, 4'h8, 1'b0, 1'b0, 2'd1); eoi = 1'b0;
    tick("pr_req3", 4'h0, 4'h8, 1'b1, 1'b0, 2'd3);
    irq_ack = 1'b1; tick("pr_ack3", 4'h0, 4'h0, 1'b0, 1'b1, 2'd3); irq_ack = 1'b0;
    eoi = 1'b1; tick("pr_eoi3", 4'h0, 4'h0, 1'b0, 1'b0, 2'd3); eoi = 1'b0;

    // ie gating, withdrawal, ack beating ie=0
    ie = 1'b0; irq = 4'b0001; tick("ie0_pend", 4'h0, 4'h1, 1'b0, 1'b0, 2'd3); irq = 4'h0;
    tick("ie0_hold", 4'h0, 4'h1, 1'b0, 1'b0, 2'd3);
    ie = 1'b1; tick("ie1_req", 4'h0, 4'h1, 1'b1, 1'b0, 2'd0);
    ie = 1'b0; tick("withdraw", 4'h0, 4'h1, 1'b0, 1'b0, 2'd0);
    ie = 1'b1; tick("rereq", 4'h0, 4'h1, 1'b1, 1'b0, 2'd0);
    ie = 1'b0; irq_ack = 1'b1; tick("ack_vs_ie0", 4'h0, 4'h0, 1'b0, 1'b1, 2'd0);
    irq_ack = 1'b0; ie = 1'b1;
    eoi = 1'b1; tick("eoi0", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0); eoi = 1'b0;
    irq_ack = 1'b1; tick("ack_idle", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0); irq_ack = 1'b0;

    // vector stability in REQ; mask under request does not withdraw
    irq = 4'b0100; tick("st_pend2", 4'h0, 4'h4, 1'b0, 1'b0, 2'd0); irq = 4'h0;
    tick("st_req2", 4'h0, 4'h4, 1'b1, 1'b0, 2'd2);
    irq = 4'b0001; tick("st_hi_pend", 4'h0, 4'h5, 1'b1, 1'b0, 2'd2); irq = 4'h0;
    tick("st_stable", 4'h0, 4'h5, 1'b1, 1'b0, 2'd2);
    mask_we = 1'b1; mask_in = 4'h4; tick("st_mask", 4'h4, 4'h5, 1'b1, 1'b0, 2'd2);
    mask_in = 4'h0; tick("st_unmask", 4'h0, 4'h5, 1'b1, 1'b0, 2'd2); mask_we = 1'b0;
    irq_ack = 1'b1; tick("st_ack", 4'h0, 4'h1, 1'b0, 1'b1, 2'd2); irq_ack = 1'b0;
    eoi = 1'b1; tick("st_eoi", 4'h0, 4'h1, 1'b0, 1'b0, 2'd2); eoi = 1'b0;
    tick("st_req0", 4'h0, 4'h1, 1'b1, 1'b0, 2'd0);
    irq_ack = 1'b1; tick("st_ack0", 4'h0, 4'h0, 1'b0, 1'b1, 2'd0); irq_ack = 1'b0;

    // reset during SVC, eoi afterwards ignored
    reset = 1'b0; tick("svc_reset", 4'hF, 4'h0, 1'b0, 1'b0, 2'd0); reset = 1'b1;
    eoi = 1'b1; tick("post_rst_eoi", 4'hF, 4'h0, 1'b0, 1'b0, 2'd0); eoi = 1'b0;

    // held line across acknowledge
    mask_we = 1'b1; mask_in = 4'h0; tick("h_mask", 4'h0, 4'h0, 1'b0, 1'b0, 2'd0); mask_we = 1'b0;
    irq = 4'b0100;
    tick("h_pend", 4'h0, 4'h4, 1'b0, 1'b0, 2'd0);
    tick("h_req", 4'h0, 4'h4, 1'b1, 1'b0, 2'd2);
    irq_ack = 1'b1; tick("h_ack", 4'h0, HELD_P, 1'b0, 1'b1, 2'd2); irq_ack = 1'b0;
    for (int i = 0; i < 7; i++) tick("h_svc", 4'h0, HELD_P, 1'b0, 1'b1, 2'd2);
    irq = 4'h0;
    eoi = 1'b1; tick("h_eoi", 4'h0, HELD_P, 1'b0, 1'b0, 2'd2); eoi = 1'b0;
    tick("h_after", 4'h0, HELD_P, (HELD_P != 4'h0), 1'b0, 2'd2);

    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog bound on the whole run.
  initial begin
    #100000;
    if (!stim_done) begin
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
